// File: rtl/vmask_scan_pkg.sv
// Shared vALU mask-scan definitions.
// Holds the opSel encodings used by the mask-scan unit. Encodings 101..111 are reserved.
package vmask_scan_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_CPOP  = 3'b000,
      OP_FIRST = 3'b001,
      OP_MSBF  = 3'b010,
      OP_MSIF  = 3'b011,
      OP_MSOF  = 3'b100
   } vmask_op_e;

endpackage

// File: rtl/vmask_scan_ffs.sv
// Combinational find-first-set over one mask beat.
// Ports:
//   vec    in   W          mask to scan
//   any    out  1          vec has at least one set bit
//   idx    out  log2(W)    position of the lowest set bit (0 when any=0)
//   onehot out  W          lowest set bit isolated (0 when any=0)
//   below  out  W          ones strictly below the lowest set bit (all-ones when any=0)
//   incl   out  W          ones up to and including the lowest set bit (all-ones when any=0)
module vmask_ffs
   import vmask_scan_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [W-1:0]         vec,
   output logic                 any,
   output logic [$clog2(W)-1:0] idx,
   output logic [W-1:0]         onehot,
   output logic [W-1:0]         below,
   output logic [W-1:0]         incl
);

   localparam int IW = $clog2(W);

   always_comb begin
      any    = |vec;
      // Two's-complement trick: vec & -vec keeps only the lowest set bit.
      onehot = vec & (~vec + W'(1));
      // With no set bit the whole beat lies "before" the first, so both masks are full.
      below  = any ? (onehot - W'(1)) : '1;
      incl   = below | onehot;
      idx    = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/vmask_scan.sv
// RVV mask-scan unit: vcpop.m, vfirst.m, vmsbf.m, vmsif.m, vmsof.m.
// A register group streams through as beats framed by in_start/in_end; scan state
// carries across beats. Fixed 3-cycle latency, one beat per cycle, no backpressure.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_m0         source mask beat (vs2)
//   in_m1         active-element mask (v0 & body, combined upstream)
//   in_valid      beat valid; in_start/in_end/in_opSel are qualified by it
//   out_vec       per-beat result mask (msbf/msif/msof; 0 for other ops)
//   out_valid     out_vec valid, one per accepted beat
//   out_scalar    vcpop count / vfirst index, 0 unless out_sc_valid
//   out_sc_valid  scalar valid, on the beat that carried in_end
module vmask_scan
   import vmask_scan_pkg::*;
#(
   parameter int REQ_DATA_WIDTH  = 64,
   parameter int RESP_DATA_WIDTH = 64,
   parameter int OPSEL_WIDTH     = 3,
   parameter int SCALAR_WIDTH    = 32,
   parameter int BEAT_CNT_WIDTH  = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [REQ_DATA_WIDTH-1:0]  in_m0,
   input  logic [REQ_DATA_WIDTH-1:0]  in_m1,
   input  logic                       in_valid,
   input  logic                       in_start,
   input  logic                       in_end,
   input  logic [OPSEL_WIDTH-1:0]     in_opSel,
   output logic [RESP_DATA_WIDTH-1:0] out_vec,
   output logic                       out_valid,
   output logic [SCALAR_WIDTH-1:0]    out_scalar,
   output logic                       out_sc_valid
);

   localparam int IDX_W = $clog2(REQ_DATA_WIDTH);
   localparam int CNT_W = IDX_W + 1;

   // Pairwise adder tree over the beat's bits.
   function automatic logic [CNT_W-1:0] popcount(input logic [REQ_DATA_WIDTH-1:0] v);
      logic [CNT_W-1:0] s [REQ_DATA_WIDTH];
      for (int i = 0; i < REQ_DATA_WIDTH; i++) s[i] = CNT_W'(v[i]);
      for (int w = REQ_DATA_WIDTH / 2; w > 0; w = w / 2) begin
         for (int i = 0; i < w; i++) s[i] = s[2*i] + s[2*i+1];
      end
      return s[0];
   endfunction

   // Accumulate with saturation at all-ones.
   function automatic logic [SCALAR_WIDTH-1:0] sat_add(input logic [SCALAR_WIDTH-1:0] acc,
                                                       input logic [CNT_W-1:0]        inc);
      logic [SCALAR_WIDTH:0] sum;
      sum = {1'b0, acc} + (SCALAR_WIDTH+1)'(inc);
      return sum[SCALAR_WIDTH] ? '1 : sum[SCALAR_WIDTH-1:0];
   endfunction

   // ---- s0: register inputs, gated by in_valid ----
   logic                      vld_p0, start_p0, end_p0;
   logic [OPSEL_WIDTH-1:0]    op_p0;
   logic [REQ_DATA_WIDTH-1:0] m0_p0, m1_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0   <= 1'b0;
         start_p0 <= 1'b0;
         end_p0   <= 1'b0;
         op_p0    <= '0;
         m0_p0    <= '0;
         m1_p0    <= '0;
      end else begin
         vld_p0   <= in_valid;
         start_p0 <= in_valid & in_start;
         end_p0   <= in_valid & in_end;
         op_p0    <= in_opSel & {OPSEL_WIDTH{in_valid}};
         m0_p0    <= in_m0 & {REQ_DATA_WIDTH{in_valid}};
         m1_p0    <= in_m1 & {REQ_DATA_WIDTH{in_valid}};
      end
   end

   // ---- s1: scan computation and state update ----
   logic                      scan_found;
   logic [SCALAR_WIDTH-1:0]   scan_pop, scan_fidx;
   logic [BEAT_CNT_WIDTH-1:0] scan_bidx;

   logic [REQ_DATA_WIDTH-1:0] act;
   logic                      ffs_any;
   logic [IDX_W-1:0]          ffs_idx;
   logic [REQ_DATA_WIDTH-1:0] ffs_onehot, ffs_below, ffs_incl;

   assign act = m0_p0 & m1_p0;

   vmask_ffs #(.W(REQ_DATA_WIDTH)) u_ffs (
      .vec    (act),
      .any    (ffs_any),
      .idx    (ffs_idx),
      .onehot (ffs_onehot),
      .below  (ffs_below),
      .incl   (ffs_incl)
   );

   logic                      is_cpop, is_first, is_msbf, is_msif, is_msof, op_ok, upd;
   logic                      found_c, found_n;
   logic [SCALAR_WIDTH-1:0]   pop_c, pop_n, fidx_n, scalar_c;
   logic [BEAT_CNT_WIDTH-1:0] bidx_c, bidx_n;
   logic [REQ_DATA_WIDTH-1:0] vec_c;
   logic                      sc_vld_c;

   always_comb begin
      is_cpop  = (op_p0 == OPSEL_WIDTH'(OP_CPOP));
      is_first = (op_p0 == OPSEL_WIDTH'(OP_FIRST));
      is_msbf  = (op_p0 == OPSEL_WIDTH'(OP_MSBF));
      is_msif  = (op_p0 == OPSEL_WIDTH'(OP_MSIF));
      is_msof  = (op_p0 == OPSEL_WIDTH'(OP_MSOF));
      op_ok    = is_cpop | is_first | is_msbf | is_msif | is_msof;
      // Reserved ops and bubbles leave the scan state untouched.
      upd      = vld_p0 & op_ok;

      // A start beat sees cleared state regardless of any unfinished group.
      found_c  = start_p0 ? 1'b0 : scan_found;
      pop_c    = start_p0 ? '0   : scan_pop;
      bidx_c   = start_p0 ? '0   : scan_bidx;

      pop_n    = sat_add(pop_c, popcount(act));
      found_n  = found_c | ffs_any;
      fidx_n   = (!found_c && ffs_any) ? SCALAR_WIDTH'({bidx_c, ffs_idx}) : scan_fidx;
      bidx_n   = bidx_c + BEAT_CNT_WIDTH'(1);

      // ffs masks already cover "no bit found"; m1 removes inactive positions.
      vec_c = '0;
      if (vld_p0 && !found_c) begin
         if (is_msbf) vec_c = ffs_below & m1_p0;
         if (is_msif) vec_c = ffs_incl & m1_p0;
         if (is_msof) vec_c = ffs_onehot;
      end

      sc_vld_c = vld_p0 & end_p0 & (is_cpop | is_first);
      scalar_c = '0;
      if (sc_vld_c) scalar_c = is_cpop ? pop_n : (found_n ? fidx_n : '1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_found <= 1'b0;
         scan_pop   <= '0;
         scan_fidx  <= '0;
         scan_bidx  <= '0;
      end else if (upd) begin
         scan_found <= found_n;
         scan_pop   <= pop_n;
         scan_fidx  <= fidx_n;
         scan_bidx  <= bidx_n;
      end
   end

   logic                       vld_p1, sc_vld_p1;
   logic [RESP_DATA_WIDTH-1:0] vec_p1;
   logic [SCALAR_WIDTH-1:0]    scalar_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         sc_vld_p1 <= 1'b0;
         vec_p1    <= '0;
         scalar_p1 <= '0;
      end else begin
         vld_p1    <= vld_p0;
         sc_vld_p1 <= sc_vld_c;
         vec_p1    <= RESP_DATA_WIDTH'(vec_c);
         scalar_p1 <= scalar_c;
      end
   end

   // ---- out: result registers ----
   logic                       vld_p2, sc_vld_p2;
   logic [RESP_DATA_WIDTH-1:0] vec_p2;
   logic [SCALAR_WIDTH-1:0]    scalar_p2;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2    <= 1'b0;
         sc_vld_p2 <= 1'b0;
         vec_p2    <= '0;
         scalar_p2 <= '0;
      end else begin
         vld_p2    <= vld_p1;
         sc_vld_p2 <= sc_vld_p1;
         vec_p2    <= vec_p1;
         scalar_p2 <= scalar_p1;
      end
   end

   assign out_vec      = vec_p2;
   assign out_valid    = vld_p2;
   assign out_scalar   = scalar_p2;
   assign out_sc_valid = sc_vld_p2;

endmodule
